// File: rtl/code_lock_ctrl.sv
// Keypad password controller: edge-detects scanner strobes, buffers a fixed-length entry,
// checks it on '#', opens a timed unlock window and enforces an alarm lockout.
// Optional password change from the open state is compiled in with CODE_LOCK_CHANGE_PW_EN.
module code_lock_ctrl #(
  parameter int                  DIGITS         = 4,
  parameter logic [DIGITS*4-1:0] PASSWORD       = 16'h1234,
  parameter int                  MAX_FAIL       = 3,
  parameter int                  UNLOCK_CYCLES  = 1000,
  parameter int                  LOCKOUT_CYCLES = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       unlock,
  output logic       alarm,
  output logic       error,
  output logic       pw_changed,
  output logic [2:0] digit_cnt,
  output logic [2:0] fail_cnt
);

  localparam int BW   = DIGITS * 4;
  localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] T_UNLOCK  = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] T_LOCKOUT = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [2:0]    DIG_N     = 3'(DIGITS);
  localparam logic [3:0]    KEY_HASH  = 4'd10;
  localparam logic [3:0]    KEY_STAR  = 4'd11;

`ifdef CODE_LOCK_CHANGE_PW_EN
  typedef enum logic [2:0] {
    ST_ENTRY = 3'd0, ST_CHECK = 3'd1, ST_OPEN = 3'd2, ST_LOCKOUT = 3'd3, ST_NEWPW = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_ENTRY = 3'd0, ST_CHECK = 3'd1, ST_OPEN = 3'd2, ST_LOCKOUT = 3'd3
  } state_t;
`endif

  state_t          state_r, state_s;
  logic            v1_r, v2_r;
  logic [BW-1:0]   entry_r, entry_s, col_entry_s;
  logic [2:0]      cnt_r, cnt_s, col_cnt_s;
  logic            ovf_r, ovf_s, col_ovf_s;
  logic [2:0]      fail_r, fail_s, fail_inc_s;
  logic [TW-1:0]   timer_r, timer_s;
  logic            error_s, pwchg_s, unlock_s;
  logic            key_ev_s, is_digit_s, match_s;
  logic [BW-1:0]   pw_cur_s;
  logic            unlock_r, alarm_r, error_r, pwchg_r;

`ifdef CODE_LOCK_CHANGE_PW_EN
  logic [BW-1:0]   pw_r, pw_nxt_s;
  assign pw_cur_s = pw_r;
`else
  assign pw_cur_s = PASSWORD;
`endif

  assign key_ev_s   = v1_r & ~v2_r;
  assign is_digit_s = key_code < 4'd10;
  assign match_s    = (cnt_r == DIG_N) & ~ovf_r & (entry_r == pw_cur_s);
  assign fail_inc_s = (fail_r == 3'd7) ? 3'd7 : fail_r + 3'd1;

  // Effect of the current key on the entry buffer, shared by ENTRY and NEWPW.
  always_comb begin
    col_entry_s = entry_r;
    col_cnt_s   = cnt_r;
    col_ovf_s   = ovf_r;
    if (is_digit_s) begin
      if (cnt_r < DIG_N) begin
        col_entry_s = (entry_r << 3'd4) | BW'(key_code);
        col_cnt_s   = cnt_r + 3'd1;
      end else begin
        col_ovf_s = 1'b1;
      end
    end else if (key_code == KEY_STAR) begin
      col_entry_s = {BW{1'b0}};
      col_cnt_s   = 3'd0;
      col_ovf_s   = 1'b0;
    end else begin
      col_entry_s = entry_r;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_s = state_r;
    entry_s = entry_r;
    cnt_s   = cnt_r;
    ovf_s   = ovf_r;
    fail_s  = fail_r;
    timer_s = timer_r;
    error_s = 1'b0;
    pwchg_s = 1'b0;
`ifdef CODE_LOCK_CHANGE_PW_EN
    pw_nxt_s = pw_r;
`endif
    case (state_r)
      ST_ENTRY: begin
        if (key_ev_s) begin
          if (key_code == KEY_HASH) begin
            state_s = ST_CHECK;
          end else begin
            entry_s = col_entry_s;
            cnt_s   = col_cnt_s;
            ovf_s   = col_ovf_s;
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_CHECK: begin
        entry_s = {BW{1'b0}};
        cnt_s   = 3'd0;
        ovf_s   = 1'b0;
        if (match_s) begin
          fail_s  = 3'd0;
          timer_s = T_UNLOCK;
          state_s = ST_OPEN;
        end else begin
          error_s = 1'b1;
          fail_s  = fail_inc_s;
          if (32'(fail_inc_s) == MAX_FAIL) begin
            timer_s = T_LOCKOUT;
            state_s = ST_LOCKOUT;
          end else begin
            state_s = ST_ENTRY;
          end
        end
      end
      ST_OPEN: begin
        // Expiry wins over a coincident key event.
        if (timer_r == {TW{1'b0}}) begin
          state_s = ST_ENTRY;
        end else if (key_ev_s && (key_code == KEY_HASH)) begin
          state_s = ST_ENTRY;
`ifdef CODE_LOCK_CHANGE_PW_EN
        end else if (key_ev_s && (key_code == KEY_STAR)) begin
          state_s = ST_NEWPW;
`endif
        end else begin
          timer_s = timer_r - {{(TW-1){1'b0}}, 1'b1};
        end
      end
      ST_LOCKOUT: begin
        if (timer_r == {TW{1'b0}}) begin
          fail_s  = 3'd0;
          state_s = ST_ENTRY;
        end else begin
          timer_s = timer_r - {{(TW-1){1'b0}}, 1'b1};
        end
      end
`ifdef CODE_LOCK_CHANGE_PW_EN
      ST_NEWPW: begin
        if (key_ev_s && (key_code == KEY_HASH)) begin
          if ((cnt_r == DIG_N) && !ovf_r) begin
            pw_nxt_s = entry_r;
            pwchg_s  = 1'b1;
          end else begin
            error_s = 1'b1;
          end
          entry_s = {BW{1'b0}};
          cnt_s   = 3'd0;
          ovf_s   = 1'b0;
          state_s = ST_ENTRY;
        end else if (key_ev_s) begin
          entry_s = col_entry_s;
          cnt_s   = col_cnt_s;
          ovf_s   = col_ovf_s;
        end else begin
          state_s = state_r;
        end
      end
`endif
      default: begin
        state_s = ST_ENTRY;
      end
    endcase
  end

`ifdef CODE_LOCK_CHANGE_PW_EN
  assign unlock_s = (state_s == ST_OPEN) || (state_s == ST_NEWPW);
`else
  assign unlock_s = (state_s == ST_OPEN);
`endif

  // State, datapath and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r  <= ST_ENTRY;
      v1_r     <= 1'b0;
      v2_r     <= 1'b0;
      entry_r  <= {BW{1'b0}};
      cnt_r    <= 3'd0;
      ovf_r    <= 1'b0;
      fail_r   <= 3'd0;
      timer_r  <= {TW{1'b0}};
      unlock_r <= 1'b0;
      alarm_r  <= 1'b0;
      error_r  <= 1'b0;
      pwchg_r  <= 1'b0;
`ifdef CODE_LOCK_CHANGE_PW_EN
      pw_r     <= PASSWORD;
`endif
    end else begin
      state_r  <= state_s;
      v1_r     <= key_valid;
      v2_r     <= v1_r;
      entry_r  <= entry_s;
      cnt_r    <= cnt_s;
      ovf_r    <= ovf_s;
      fail_r   <= fail_s;
      timer_r  <= timer_s;
      unlock_r <= unlock_s;
      alarm_r  <= (state_s == ST_LOCKOUT);
      error_r  <= error_s;
      pwchg_r  <= pwchg_s;
`ifdef CODE_LOCK_CHANGE_PW_EN
      pw_r     <= pw_nxt_s;
`endif
    end
  end

  assign unlock     = unlock_r;
  assign alarm      = alarm_r;
  assign error      = error_r;
  assign pw_changed = pwchg_r;
  assign digit_cnt  = cnt_r;
  assign fail_cnt   = fail_r;

endmodule

// File: doc/code_lock_ctrl.md
Name: code_lock_ctrl

Overview:
- Password-checking controller for the door lock; sits directly downstream of the keypad scanner.
- Consumes the scanner's 4-bit key code and valid strobe.
- Accumulates a fixed-length digit entry and compares it against the stored password on '#'.
- Drives the unlock output for a timed window; enforces an alarm lockout after repeated failures.

Parameters:
- DIGITS, 4: password length in digits (1..7).
- PASSWORD, 16'h1234: reset password, 4 bits per digit, first entered digit in the MS nibble; width DIGITS*4.
- MAX_FAIL, 3: consecutive failed checks that trigger lockout (>=1).
- UNLOCK_CYCLES, 1000: clock cycles unlock stays high.
- LOCKOUT_CYCLES, 5000: clock cycles alarm/lockout lasts.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- key_code  input  4  scanner code: 0-9 digits, 10 '#', 11 '*', 12-15 ignored.
- key_valid  input  1  scanner key-detect strobe; key_code is valid one cycle after it rises.
- unlock  output  1  lock open.
- alarm  output  1  lockout active.
- error  output  1  one-cycle pulse on a failed check.
- pw_changed  output  1  one-cycle pulse on password update (optional feature; tied 0 when the feature is compiled out).
- digit_cnt  output  3  digits currently buffered.
- fail_cnt  output  3  consecutive failures so far.

Behaviour:
- Reset (synchronous, active-high, one clock; clock and reset port names as stated in Ports):
  - state=ENTRY; unlock, alarm, error, pw_changed, digit_cnt, fail_cnt = 0.
  - Buffer, overflow flag and timer cleared; pw_reg=PASSWORD.
  - Reset mid-operation aborts any entry, open window or lockout.
- Key event:
  - v1 <= key_valid, v2 <= v1.
  - event = v1 & ~v2, i.e. the cycle after a key_valid rising edge; key_code is sampled in that cycle.
  - key_valid held high produces exactly one event.
- ENTRY:
  - Digit 0-9 with digit_cnt<DIGITS: buf <= {buf[DIGITS*4-5:0], digit}, digit_cnt++.
  - Digit with digit_cnt==DIGITS: dropped; ovf<=1.
  - '*': clears buf, digit_cnt and ovf.
  - '#': go to CHECK.
  - Codes 12-15: no effect.
- CHECK (exactly 1 cycle):
  - match = (digit_cnt==DIGITS) & ~ovf & (buf==pw_reg).
  - buf, digit_cnt and ovf are cleared on exit.
  - match: fail_cnt<=0, timer<=UNLOCK_CYCLES-1, go to OPEN. unlock rises in the cycle after CHECK, i.e. 2 cycles after the '#' event.
  - no match: error=1 for one cycle; fail_cnt++.
    - If the new fail_cnt==MAX_FAIL: timer<=LOCKOUT_CYCLES-1, go to LOCKOUT.
    - Otherwise go to ENTRY.
- OPEN:
  - unlock=1; timer decrements each cycle.
  - At 0, go to ENTRY (unlock high for exactly UNLOCK_CYCLES cycles).
  - A '#' event relocks immediately: next state ENTRY.
  - Digits ignored; '*' handled as described under Optional Feature.
- LOCKOUT:
  - alarm=1; all key events ignored; timer counts down.
  - At 0: fail_cnt<=0, go to ENTRY (alarm high exactly LOCKOUT_CYCLES cycles).
- Simultaneous events:
  - A key event in the same cycle as a timer expiry is ignored.
  - No event is possible in CHECK (events are at least 2 cycles apart).
- Timer width: $clog2 of max(UNLOCK_CYCLES, LOCKOUT_CYCLES)+1. fail_cnt saturates at 7.

Optional Feature:
- Macro: CODE_LOCK_CHANGE_PW_EN.
- Defined:
  - '*' in OPEN enters NEWPW; unlock stays 1 and the timer freezes.
  - NEWPW collects digits as in ENTRY; '*' clears.
  - '#' with digit_cnt==DIGITS and ~ovf: pw_reg<=buf, pw_changed=1 for one cycle.
  - '#' otherwise: error=1 for one cycle, pw_reg unchanged.
  - Either way: buffer cleared, go to ENTRY (locked); fail_cnt not incremented.
- Undefined:
  - No NEWPW state; pw_reg is the constant PASSWORD.
  - '*' in OPEN ignored; pw_changed tied 0.

Test Plan (UNLOCK_CYCLES=20, LOCKOUT_CYCLES=30, defaults otherwise):
- Keys 1,2,3,4,'#' -> unlock high 2 cycles after the '#' event for exactly 20 cycles; fail_cnt=0; error never pulses.
- Keys 1,2,3,'#' then 1,2,3,4,5,'#' -> two error pulses (short entry, then overflow); fail_cnt=2; unlock stays 0.
- Three wrong entries 9,9,9,9,'#' -> third check raises alarm for 30 cycles; keys 1,2,3,4,'#' during alarm ignored; then alarm=0, fail_cnt=0.
- Keys 5,'*',1,2,3,4,'#' -> unlock; then '#' in OPEN -> unlock drops the next cycle.
- key_valid held high 10 cycles with code 1 -> digit_cnt=1 only; codes 12-15 -> digit_cnt unchanged.
- With CODE_LOCK_CHANGE_PW_EN: unlock via 1234, '*',4,3,2,1,'#' -> pw_changed pulse, locked; 1234# -> error; 4321# -> unlock.
